// File: rtl/burgertime_pkg.sv
// ============================================================================
// Module   : burgertime_pkg
// Brief    : Shared types and helpers for the chef hazard monitor slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package burgertime_pkg;

    typedef logic [9:0] coord_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FREEZE = 3'd1,
        HURT   = 3'd2,
        GRACE  = 3'd3,
        OVER   = 3'd4
    } hazard_state_t;

    localparam int NUM_ENEMIES = 2;

    // Unsigned distance; never wraps because the larger operand is always the minuend.
    function automatic coord_t absdiff(input coord_t a, input coord_t b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

`default_nettype wire

// File: rtl/chef_hazard_monitor_if.sv
// ============================================================================
// Module   : chef_hazard_monitor_if
// Brief    : Positions/lives in, death sequencing outputs back to the game.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface chef_hazard_monitor_if;
    import burgertime_pkg::*;

    coord_t      ChefX;
    coord_t      ChefY;
    coord_t      Enemy0X;
    coord_t      Enemy0Y;
    coord_t      Enemy1X;
    coord_t      Enemy1Y;
    logic [1:0]  enemy_active;
    logic [1:0]  lives;
    logic [1:0]  enemy_hurt;
    logic        freeze;
    logic        invuln;
    logic        game_over;

    modport master (
        output ChefX, ChefY, Enemy0X, Enemy0Y, Enemy1X, Enemy1Y,
        output enemy_active, lives,
        input  enemy_hurt, freeze, invuln, game_over
    );

    modport slave (
        input  ChefX, ChefY, Enemy0X, Enemy0Y, Enemy1X, Enemy1Y,
        input  enemy_active, lives,
        output enemy_hurt, freeze, invuln, game_over
    );

endinterface

`default_nettype wire

// File: rtl/hitbox_overlap.sv
// ============================================================================
// Module   : hitbox_overlap
// Brief    : Combinational square-hitbox overlap test between two points.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hitbox_overlap
    import burgertime_pkg::*;
#(
    parameter int HIT_BOX = 8
) (
    input  coord_t ax,
    input  coord_t ay,
    input  coord_t bx,
    input  coord_t by,
    input  logic   en,
    output logic   hit
);

    localparam coord_t c_hit_box = coord_t'(HIT_BOX);

    assign hit = en && (absdiff(ax, bx) < c_hit_box) && (absdiff(ay, by) < c_hit_box);

endmodule

`default_nettype wire

// File: rtl/chef_hazard_monitor.sv
// ============================================================================
// Module   : chef_hazard_monitor
// Brief    : Detects chef/enemy contact and sequences freeze -> hurt -> grace.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module chef_hazard_monitor
    import burgertime_pkg::*;
#(
    parameter int HIT_BOX       = 8,
    parameter int FREEZE_FRAMES = 60,
    parameter int GRACE_FRAMES  = 120,
    parameter int CNT_W         = 8
) (
    input  logic                  frame_clk,
    input  logic                  Reset,
    chef_hazard_monitor_if.slave  bus
);

    localparam logic [CNT_W-1:0] c_freeze_last = CNT_W'(FREEZE_FRAMES - 1);
    localparam logic [CNT_W-1:0] c_grace_last  = CNT_W'(GRACE_FRAMES - 1);
    localparam logic [CNT_W-1:0] c_one         = CNT_W'(1);

    coord_t                  enemy_x [NUM_ENEMIES];
    coord_t                  enemy_y [NUM_ENEMIES];
    logic [NUM_ENEMIES-1:0]  hit_vec;

    hazard_state_t           state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_ENEMIES-1:0]  mask_q, mask_d;
    logic [NUM_ENEMIES-1:0]  enemy_hurt_q;
    logic                    freeze_q;
    logic                    invuln_q;
    logic                    game_over_q;

    assign enemy_x[0] = bus.Enemy0X;
    assign enemy_y[0] = bus.Enemy0Y;
    assign enemy_x[1] = bus.Enemy1X;
    assign enemy_y[1] = bus.Enemy1Y;

    generate
        for (genvar i = 0; i < NUM_ENEMIES; i++) begin : g_hit
            hitbox_overlap #(
                .HIT_BOX (HIT_BOX)
            ) u_hitbox (
                .ax  (bus.ChefX),
                .ay  (bus.ChefY),
                .bx  (enemy_x[i]),
                .by  (enemy_y[i]),
                .en  (bus.enemy_active[i]),
                .hit (hit_vec[i])
            );
        end
    endgenerate

    // Overlaps are only looked at in IDLE; once a death starts it runs to completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        case (state_q)
            IDLE: begin
                if (bus.lives == 2'd0) begin
                    state_d = OVER;
                end else if (|hit_vec) begin
                    state_d = FREEZE;
                    mask_d  = hit_vec;
                    cnt_d   = c_freeze_last;
                end
            end
            FREEZE: begin
                if (cnt_q != '0) cnt_d   = cnt_q - c_one;
                else             state_d = HURT;
            end
            HURT: begin
                state_d = GRACE;
                cnt_d   = c_grace_last;
            end
            GRACE: begin
                if (bus.lives == 2'd0) begin
                    state_d = OVER;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - c_one;
                end else begin
                    state_d = IDLE;
                    mask_d  = '0;
                end
            end
            OVER:    state_d = OVER;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with state_q.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            mask_q       <= '0;
            enemy_hurt_q <= '0;
            freeze_q     <= 1'b0;
            invuln_q     <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mask_q       <= mask_d;
            enemy_hurt_q <= (state_d == HURT) ? mask_d : '0;
            freeze_q     <= (state_d == FREEZE) || (state_d == HURT) || (state_d == OVER);
            invuln_q     <= (state_d == GRACE);
            game_over_q  <= (state_d == OVER);
        end
    end

    assign bus.enemy_hurt = enemy_hurt_q;
    assign bus.freeze     = freeze_q;
    assign bus.invuln     = invuln_q;
    assign bus.game_over  = game_over_q;

endmodule

`default_nettype wire

// File: tb/tb_chef_hazard_monitor.sv
// ============================================================================
// Module   : tb_chef_hazard_monitor
// Brief    : Self-checking bench for chef_hazard_monitor with a timeline model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_chef_hazard_monitor;
    import burgertime_pkg::*;

    localparam int HB = 8;
    localparam int FF = 40;
    localparam int GF = 12;

    localparam int PH_IDLE  = 0;
    localparam int PH_FRZ   = 1;
    localparam int PH_HURT  = 2;
    localparam int PH_GRACE = 3;

    logic frame_clk = 1'b0;
    logic Reset     = 1'b1;

    chef_hazard_monitor_if bus ();

    chef_hazard_monitor #(
        .HIT_BOX       (HB),
        .FREEZE_FRAMES (FF),
        .GRACE_FRAMES  (GF),
        .CNT_W         (8)
    ) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus)
    );

    always #5 frame_clk = ~frame_clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: a death is a timeline anchored at the edge e0 where it was detected.
    int         t       = 0;
    int         e0      = -1;
    bit         ov      = 1'b0;
    logic [1:0] m_mask  = 2'b00;
    int         m_lives = 3;
    logic [4:0] exp_o   = 5'b0;

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic bit ovl(input int cx, input int cy, input int ex, input int ey);
        return (absd(cx, ex) < HB) && (absd(cy, ey) < HB);
    endfunction

    function automatic logic [1:0] cur_hit();
        logic [1:0] h;
        h[0] = bus.enemy_active[0] && ovl(int'(bus.ChefX), int'(bus.ChefY), int'(bus.Enemy0X), int'(bus.Enemy0Y));
        h[1] = bus.enemy_active[1] && ovl(int'(bus.ChefX), int'(bus.ChefY), int'(bus.Enemy1X), int'(bus.Enemy1Y));
        return h;
    endfunction

    function automatic int phase_of(input int tt);
        int r;
        if (e0 < 0 || tt < e0) return PH_IDLE;
        r = tt - e0;
        if (r < FF)       return PH_FRZ;
        if (r == FF)      return PH_HURT;
        if (r <= FF + GF) return PH_GRACE;
        return PH_IDLE;
    endfunction

    function automatic logic [4:0] got();
        return {bus.enemy_hurt, bus.freeze, bus.invuln, bus.game_over};
    endfunction

    task automatic place(input int cx, input int cy, input int x0, input int y0,
                         input int x1, input int y1, input logic [1:0] act);
        bus.ChefX        = coord_t'(cx);
        bus.ChefY        = coord_t'(cy);
        bus.Enemy0X      = coord_t'(x0);
        bus.Enemy0Y      = coord_t'(y0);
        bus.Enemy1X      = coord_t'(x1);
        bus.Enemy1Y      = coord_t'(y1);
        bus.enemy_active = act;
    endtask

    // One frame: the model consumes the inputs sampled at this edge, the chef
    // loses a life right after the edge that ends the hurt frame.
    task automatic tick();
        int         prev;
        int         ph;
        logic [1:0] h;
        bit         dec;
        @(posedge frame_clk);
        t++;
        h   = cur_hit();
        dec = 1'b0;
        if (Reset) begin
            e0 = -1; ov = 1'b0; m_mask = 2'b00;
            exp_o = 5'b0;
        end else begin
            prev = phase_of(t - 1);
            if (!ov) begin
                if (prev == PH_IDLE) begin
                    if (m_lives == 0) ov = 1'b1;
                    else if (h != 2'b00) begin e0 = t; m_mask = h; end
                end else if (prev == PH_GRACE && m_lives == 0) begin
                    ov = 1'b1;
                end
            end
            dec = (prev == PH_HURT) && !ov && (m_lives > 0);
            if (ov) begin
                exp_o = 5'b00101;
            end else begin
                ph = phase_of(t);
                exp_o = {(ph == PH_HURT) ? m_mask : 2'b00,
                         (ph == PH_FRZ) || (ph == PH_HURT),
                         (ph == PH_GRACE), 1'b0};
            end
        end
        #1;
        if (dec) m_lives--;
        bus.lives = m_lives[1:0];
    endtask

    task automatic hold_reset();
        Reset = 1'b1;
        e0 = -1; ov = 1'b0; m_mask = 2'b00; exp_o = 5'b0;
        #1;
        tick();
        @(negedge frame_clk);
        Reset = 1'b0;
    endtask

    task automatic set_lives(input int n);
        m_lives   = n;
        bus.lives = m_lives[1:0];
    endtask

    task automatic test_reset();
        place(100, 100, 100, 100, 100, 100, 2'b11);
        set_lives(3);
        Reset = 1'b1;
        #1;
        n_cmp++;
        if (got() !== 5'b0) begin
            $display("FAIL reset_async got=%b exp=%b", got(), 5'b0); n_fail++;
        end
        hold_reset();
        n_cmp++;
        if (got() !== 5'b0) begin
            $display("FAIL reset_release got=%b exp=%b", got(), 5'b0); n_fail++;
        end
    endtask

    task automatic test_basic();
        int pulses = 0;
        int pf     = -1;
        hold_reset();
        set_lives(3);
        place(100, 100, 107, 100, 500, 400, 2'b01);
        for (int i = 1; i <= FF + GF + 4; i++) begin
            tick();
            if (i == 1) place(100, 100, 300, 300, 500, 400, 2'b01);
            n_cmp++;
            if (got() !== exp_o) begin
                $display("FAIL basic frame=%0d got=%b exp=%b", i, got(), exp_o); n_fail++;
            end
            if (bus.enemy_hurt !== 2'b00) begin pulses++; pf = i; end
        end
        n_cmp++;
        if (pulses !== 1 || pf !== FF + 1) begin
            $display("FAIL basic_pulse count=%0d at=%0d exp count=1 at=%0d", pulses, pf, FF + 1); n_fail++;
        end
    endtask

    task automatic test_boundary();
        int offs [8] = '{8, -8, 7, -7, 8, -8, 7, -7};
        int cx, cy, ex, ey;
        logic exp_f;
        for (int k = 0; k < 8; k++) begin
            hold_reset();
            set_lives(3);
            cx = 300; cy = 200;
            ex = (k < 4) ? cx + offs[k] : cx + 3;
            ey = (k < 4) ? cy - 2       : cy + offs[k];
            exp_f = (absd(cx, ex) < HB) && (absd(cy, ey) < HB);
            place(cx, cy, ex, ey, 800, 800, 2'b01);
            tick();
            n_cmp++;
            if (got() !== exp_o || bus.freeze !== exp_f) begin
                $display("FAIL boundary case=%0d got=%b exp=%b freeze_exp=%b", k, got(), exp_o, exp_f); n_fail++;
            end
        end
    endtask

    task automatic test_both();
        int pulses = 0;
        logic [1:0] pv = 2'b00;
        hold_reset();
        set_lives(3);
        place(200, 200, 205, 197, 195, 204, 2'b11);
        for (int i = 1; i <= FF + GF + 3; i++) begin
            tick();
            if (i == 2) bus.enemy_active = 2'b00;
            n_cmp++;
            if (got() !== exp_o) begin
                $display("FAIL both frame=%0d got=%b exp=%b", i, got(), exp_o); n_fail++;
            end
            if (bus.enemy_hurt !== 2'b00) begin pulses++; pv = bus.enemy_hurt; end
        end
        n_cmp++;
        if (pulses !== 1 || pv !== 2'b11) begin
            $display("FAIL both_pulse count=%0d val=%b exp count=1 val=11", pulses, pv); n_fail++;
        end
    endtask

    task automatic test_hold_through_grace();
        int pulses = 0;
        hold_reset();
        set_lives(3);
        place(400, 300, 396, 305, 900, 900, 2'b01);
        for (int i = 1; i <= 2 * (FF + GF + 2) + 2; i++) begin
            tick();
            n_cmp++;
            if (got() !== exp_o) begin
                $display("FAIL hold frame=%0d got=%b exp=%b", i, got(), exp_o); n_fail++;
            end
            if (bus.enemy_hurt !== 2'b00) pulses++;
            if (i == FF + GF + 2 || i == FF + GF + 3) begin
                n_cmp++;
                if (bus.freeze !== (i == FF + GF + 3)) begin
                    $display("FAIL hold_refreeze frame=%0d freeze=%b", i, bus.freeze); n_fail++;
                end
            end
        end
        n_cmp++;
        if (pulses !== 2) begin
            $display("FAIL hold_pulses got=%0d exp=2", pulses); n_fail++;
        end
    endtask

    task automatic test_game_over();
        hold_reset();
        set_lives(1);
        place(50, 60, 45, 60, 900, 900, 2'b01);
        for (int i = 1; i <= FF + 8; i++) begin
            tick();
            n_cmp++;
            if (got() !== exp_o) begin
                $display("FAIL over frame=%0d got=%b exp=%b", i, got(), exp_o); n_fail++;
            end
        end
        n_cmp++;
        if (bus.game_over !== 1'b1 || bus.freeze !== 1'b1 || bus.enemy_hurt !== 2'b00) begin
            $display("FAIL over_sticky got=%b exp=00101", got()); n_fail++;
        end
        set_lives(3);
        hold_reset();
        n_cmp++;
        if (got() !== 5'b0) begin
            $display("FAIL over_reset got=%b exp=%b", got(), 5'b0); n_fail++;
        end
    endtask

    task automatic test_reset_mid_freeze();
        hold_reset();
        set_lives(3);
        place(600, 400, 603, 395, 900, 900, 2'b01);
        for (int i = 0; i < 1 + (FF - 1 - 30); i++) tick();
        Reset = 1'b1;
        e0 = -1; ov = 1'b0; exp_o = 5'b0;
        #1;
        n_cmp++;
        if (got() !== 5'b0) begin
            $display("FAIL midreset_async got=%b exp=%b", got(), 5'b0); n_fail++;
        end
        tick();
        @(negedge frame_clk);
        Reset = 1'b0;
        place(600, 400, 700, 100, 900, 900, 2'b01);
        for (int i = 1; i <= FF + 5; i++) begin
            tick();
            n_cmp++;
            if (got() !== exp_o || bus.enemy_hurt !== 2'b00) begin
                $display("FAIL midreset frame=%0d got=%b exp=%b", i, got(), exp_o); n_fail++;
            end
        end
    endtask

    task automatic test_inactive();
        hold_reset();
        set_lives(3);
        place(128, 128, 128, 128, 128, 128, 2'b00);
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_cmp++;
            if (got() !== 5'b0 || exp_o !== 5'b0) begin
                $display("FAIL inactive frame=%0d got=%b exp=%b", i, got(), 5'b0); n_fail++;
            end
        end
    endtask

    task automatic test_random();
        int cx = 500, cy = 300;
        int over_frames = 0;
        hold_reset();
        set_lives(3);
        for (int i = 1; i <= 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                cx = 20 + int'($urandom_range(0, 980));
                cy = 20 + int'($urandom_range(0, 980));
            end
            place(cx, cy,
                  cx + int'($urandom_range(0, 24)) - 12, cy + int'($urandom_range(0, 24)) - 12,
                  cx + int'($urandom_range(0, 24)) - 12, cy + int'($urandom_range(0, 24)) - 12,
                  ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 399) == 0) begin
                Reset = 1'b1;
                e0 = -1; ov = 1'b0; exp_o = 5'b0;
                #1;
                n_cmp++;
                if (got() !== 5'b0) begin
                    $display("FAIL rand_async frame=%0d got=%b", i, got()); n_fail++;
                end
                tick();
                @(negedge frame_clk);
                Reset = 1'b0;
                set_lives(3);
                continue;
            end
            tick();
            n_cmp++;
            if (got() !== exp_o) begin
                $display("FAIL random frame=%0d got=%b exp=%b", i, got(), exp_o); n_fail++;
            end
            over_frames = ov ? over_frames + 1 : 0;
            if (over_frames > 5) begin
                set_lives(3);
                hold_reset();
                over_frames = 0;
            end
        end
    endtask

    initial begin
        place(0, 0, 900, 900, 900, 900, 2'b00);
        bus.lives = 2'd3;
        test_reset();
        test_basic();
        test_boundary();
        test_both();
        test_hold_through_grace();
        test_game_over();
        test_reset_mid_freeze();
        test_inactive();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
